i2cmb_wb_sequencer: RTL

//  Wishbone master that sits directly upstream of the IICMB controller (iicmb_m_wb) and drives it.

---
 rtl/i2cmb_wb_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master driving iicmb_m_wb: one host request becomes SET_BUS/START/addr/data/STOP; done_o ends each request.
// Write bytes are pulled only when the FSM needs them; read bytes are pushed with no backpressure. Optional irq timeout: I2CMB_SEQ_TIMEOUT_EN.
module i2cmb_wb_sequencer #(
  parameter int NUM_I2C_BUSSES = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rw_i,
  input  logic [3:0] req_bus_i,
  input  logic [6:0] req_addr_i,
  input  logic [3:0] req_len_i,
  input  logic [7:0] wdata_i,
  input  logic       wdata_valid_i,
  output logic       wdata_ready_o,
  output logic [7:0] rdata_o,
  output logic       rdata_valid_o,
  output logic       done_o,
  output logic [2:0] status_o,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  input  logic       irq_i
);

  localparam logic [3:0] S_INIT   = 4'd0,  S_IDLE  = 4'd1,  S_WB    = 4'd2,  S_DPR   = 4'd3;
  localparam logic [3:0] S_CMD    = 4'd4,  S_IRQ   = 4'd5,  S_EVAL  = 4'd6,  S_WWAIT = 4'd7;
  localparam logic [3:0] S_RDPR   = 4'd8,  S_RDOUT = 4'd9,  S_TORST = 4'd10, S_TORST2 = 4'd11;
  localparam logic [3:0] S_DONE   = 4'd12;

  localparam logic [2:0] P_SETBUS = 3'd0, P_START = 3'd1, P_ADDR = 3'd2;
  localparam logic [2:0] P_WDATA  = 3'd3, P_RDATA = 3'd4, P_STOP = 3'd5;

  localparam logic [1:0] A_CSR = 2'd0, A_DPR = 2'd1, A_CMDR = 2'd2;
  localparam logic [2:0] ST_OK = 3'd0, ST_NAK = 3'd1, ST_AL = 3'd2, ST_ERR = 3'd3, ST_TMO = 3'd4;
  localparam logic [4:0] NB = 5'(NUM_I2C_BUSSES);

  logic [3:0] state, ret;
  logic [2:0] phase, cmd;
  logic [7:0] dpr_val, rd_q;
  logic [6:0] addr;
  logic       rw, nak_seen;
  logic [3:0] cnt;
  logic       tmo_hit;

`ifdef I2CMB_SEQ_TIMEOUT_EN
  logic [16:0] tmo_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                   tmo_cnt <= '0;
    else if (state == S_IRQ && !irq_i) tmo_cnt <= tmo_cnt + 17'd1;
    else                            tmo_cnt <= '0;
  end

  assign tmo_hit = (state == S_IRQ) && !irq_i && (tmo_cnt == 17'(TIMEOUT_CYCLES - 1));
`else
  // Unbounded irq wait; TIMEOUT_CYCLES is referenced only so the parameter stays live.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign req_ready_o   = (state == S_IDLE);
  assign done_o        = (state == S_DONE);
  assign wdata_ready_o = (state == S_WWAIT) && wdata_valid_i;
  assign stb_o         = cyc_o;
  assign rdata_o       = rd_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_INIT;   ret <= S_IDLE;   phase <= P_SETBUS; cmd <= '0;
      dpr_val <= '0;     rd_q <= '0;      addr <= '0;        rw <= 1'b0;
      nak_seen <= 1'b0;  cnt <= '0;       status_o <= ST_OK; rdata_valid_o <= 1'b0;
      cyc_o <= 1'b0;     we_o <= 1'b0;    adr_o <= '0;       dat_o <= '0;
    end else begin
      rdata_valid_o <= 1'b0;
      case (state)
        S_INIT: begin
          cyc_o <= 1'b1; we_o <= 1'b1; adr_o <= A_CSR; dat_o <= 8'hC0;
          ret <= S_IDLE; state <= S_WB;
        end
        S_IDLE: if (req_valid_i) begin
          rw <= req_rw_i; addr <= req_addr_i; cnt <= req_len_i; nak_seen <= 1'b0;
          if ({1'b0, req_bus_i} >= NB) begin
            status_o <= ST_ERR; state <= S_DONE;
          end else begin
            phase <= P_SETBUS; dpr_val <= {4'h0, req_bus_i}; cmd <= 3'b110; state <= S_DPR;
          end
        end
        S_WB: if (ack_i) begin
          cyc_o <= 1'b0; rd_q <= dat_i; state <= ret;
          if (ret == S_RDOUT) rdata_valid_o <= 1'b1;
          if (ret == S_DONE)  status_o <= ST_TMO;
        end
        S_DPR: begin
          cyc_o <= 1'b1; we_o <= 1'b1; adr_o <= A_DPR; dat_o <= dpr_val;
          ret <= S_CMD; state <= S_WB;
        end
        S_CMD: begin
          cyc_o <= 1'b1; we_o <= 1'b1; adr_o <= A_CMDR; dat_o <= {5'b0, cmd};
          ret <= S_IRQ; state <= S_WB;
        end
        S_IRQ: begin
          if (irq_i) begin
            cyc_o <= 1'b1; we_o <= 1'b0; adr_o <= A_CMDR;
            ret <= S_EVAL; state <= S_WB;
          end else if (tmo_hit) begin
            state <= S_TORST;
          end
        end
        S_EVAL: begin
          if (rd_q[5]) begin
            status_o <= ST_AL; state <= S_DONE;
          end else if (rd_q[4]) begin
            status_o <= ST_ERR; state <= S_DONE;
          end else if (rd_q[6] && (phase == P_ADDR || phase == P_WDATA)) begin
            nak_seen <= 1'b1; phase <= P_STOP; cmd <= 3'b101; state <= S_CMD;
          end else begin
            case (phase)
              P_SETBUS: begin phase <= P_START; cmd <= 3'b100; state <= S_CMD; end
              P_START: begin
                phase <= P_ADDR; dpr_val <= {addr, rw}; cmd <= 3'b001; state <= S_DPR;
              end
              P_ADDR: begin
                if (cnt == 4'd0) begin
                  phase <= P_STOP; cmd <= 3'b101; state <= S_CMD;
                end else if (!rw) begin
                  phase <= P_WDATA; state <= S_WWAIT;
                end else begin
                  phase <= P_RDATA; cmd <= (cnt == 4'd1) ? 3'b011 : 3'b010; state <= S_CMD;
                end
              end
              P_WDATA: begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin phase <= P_STOP; cmd <= 3'b101; state <= S_CMD; end
                else state <= S_WWAIT;
              end
              P_RDATA: state <= S_RDPR;
              default: begin status_o <= nak_seen ? ST_NAK : ST_OK; state <= S_DONE; end
            endcase
          end
        end
        S_WWAIT: if (wdata_valid_i) begin
          dpr_val <= wdata_i; cmd <= 3'b001; state <= S_DPR;
        end
        S_RDPR: begin
          cyc_o <= 1'b1; we_o <= 1'b0; adr_o <= A_DPR;
          ret <= S_RDOUT; state <= S_WB;
        end
        S_RDOUT: begin
          // Last read byte is NAKed by the master, hence CMD 011 when one byte remains.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin phase <= P_STOP; cmd <= 3'b101; state <= S_CMD; end
          else begin cmd <= (cnt == 4'd2) ? 3'b011 : 3'b010; state <= S_CMD; end
        end
        S_TORST: begin
          cyc_o <= 1'b1; we_o <= 1'b1; adr_o <= A_CSR; dat_o <= 8'h00;
          ret <= S_TORST2; state <= S_WB;
        end
        S_TORST2: begin
          cyc_o <= 1'b1; we_o <= 1'b1; adr_o <= A_CSR; dat_o <= 8'hC0;
          ret <= S_DONE; state <= S_WB;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
